// File: rtl/bram_window_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_window_reader
// Function : Raster-scan read master for a 3-read-port frame BRAM. Streams the
//            vertical pixel column (y-1, y, y+1) of every scanned pixel as a
//            valid/ready beat through a 2-entry output buffer.
//            Optional macro BORDER_REPLICATE_EN: scan every row and replicate
//            the top/bottom row at the frame edges.
// Revision : 1.0
// ============================================================================
module bram_window_reader #(
    parameter int DATA_WIDTH = 22,
    parameter int ADDR_WIDTH = 18,
    parameter int IMG_WIDTH  = 384,
    parameter int IMG_HEIGHT = 384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr0,
    output logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [ADDR_WIDTH-1:0] rd_addr2,
    input  logic [DATA_WIDTH-1:0] dout0,
    input  logic [DATA_WIDTH-1:0] dout1,
    input  logic [DATA_WIDTH-1:0] dout2,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_top,
    output logic [DATA_WIDTH-1:0] m_mid,
    output logic [DATA_WIDTH-1:0] m_bot,
    output logic [15:0]           m_x,
    output logic [15:0]           m_y,
    output logic                  m_last
);

`ifdef BORDER_REPLICATE_EN
    localparam int c_Y0 = 0;
    localparam int c_Y1 = IMG_HEIGHT - 1;
`else
    localparam int c_Y0 = 1;
    localparam int c_Y1 = IMG_HEIGHT - 2;
`endif

    localparam logic [15:0]           c_X_LAST    = 16'(IMG_WIDTH - 1);
    localparam logic [15:0]           c_Y_FIRST   = 16'(c_Y0);
    localparam logic [15:0]           c_Y_LAST    = 16'(c_Y1);
    localparam logic [ADDR_WIDTH-1:0] c_ROW       = ADDR_WIDTH'(IMG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_FIRST_OFS = ADDR_WIDTH'(c_Y0 * IMG_WIDTH);

    // Buffer entry layout: {last, y, x, bot, mid, top}
    localparam int c_EW     = 3 * DATA_WIDTH + 33;
    localparam int c_X_LSB  = 3 * DATA_WIDTH;
    localparam int c_Y_LSB  = 3 * DATA_WIDTH + 16;
    localparam int c_LAST_B = 3 * DATA_WIDTH + 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic [15:0]             x_q;
    logic [15:0]             y_q;
    logic [ADDR_WIDTH-1:0]   nxt0_q;
    logic [ADDR_WIDTH-1:0]   nxt1_q;
    logic [ADDR_WIDTH-1:0]   nxt2_q;
    logic [ADDR_WIDTH-1:0]   addr0_q;
    logic [ADDR_WIDTH-1:0]   addr1_q;
    logic [ADDR_WIDTH-1:0]   addr2_q;

    logic                    infl_q;
    logic [15:0]             infl_x_q;
    logic [15:0]             infl_y_q;
    logic                    infl_last_q;

    logic                    val0_q;
    logic                    val1_q;
    logic [c_EW-1:0]         ent0_q;
    logic [c_EW-1:0]         ent1_q;

    logic                    w_pop;
    logic [1:0]              w_cnt;
    logic                    w_room;
    logic                    w_issue;
    logic                    w_row_end;
    logic                    w_last_rd;
    logic [ADDR_WIDTH-1:0]   w_a0;
    logic [ADDR_WIDTH-1:0]   w_a2;
    logic [c_EW-1:0]         w_new;

    assign w_pop     = val0_q & m_ready;
    assign w_cnt     = {1'b0, val0_q} + {1'b0, val1_q};
    assign w_room    = (w_cnt + {1'b0, infl_q}) < 2'd2;
    // A pop frees a slot on the same edge, so issuing alongside it keeps one beat per clock.
    assign w_issue   = (state_q == S_RUN) & (w_room | w_pop);
    assign w_row_end = (x_q == c_X_LAST);
    assign w_last_rd = w_row_end & (y_q == c_Y_LAST);
    assign w_new     = {infl_last_q, infl_y_q, infl_x_q, dout2, dout1, dout0};

`ifdef BORDER_REPLICATE_EN
    assign w_a0 = (y_q == c_Y_FIRST) ? nxt1_q : nxt0_q;
    assign w_a2 = (y_q == c_Y_LAST)  ? nxt1_q : nxt2_q;
`else
    assign w_a0 = nxt0_q;
    assign w_a2 = nxt2_q;
`endif

    // Raster order keeps each row's addresses contiguous, so a row change is
    // just another +1 on all three running addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            nxt0_q  <= '0;
            nxt1_q  <= '0;
            nxt2_q  <= '0;
            addr0_q <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (w_issue) begin
                addr0_q <= w_a0;
                addr1_q <= nxt1_q;
                addr2_q <= w_a2;
                nxt0_q  <= nxt0_q + 1'b1;
                nxt1_q  <= nxt1_q + 1'b1;
                nxt2_q  <= nxt2_q + 1'b1;
                if (w_row_end) begin
                    x_q <= '0;
                    y_q <= y_q + 16'd1;
                end else begin
                    x_q <= x_q + 16'd1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                        x_q     <= '0;
                        y_q     <= c_Y_FIRST;
                        nxt0_q  <= base_addr + c_FIRST_OFS - c_ROW;
                        nxt1_q  <= base_addr + c_FIRST_OFS;
                        nxt2_q  <= base_addr + c_FIRST_OFS + c_ROW;
                    end
                end
                S_RUN: begin
                    if (w_issue && w_last_rd) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!val0_q && !infl_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q      <= 1'b0;
            infl_x_q    <= '0;
            infl_y_q    <= '0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q <= w_issue;
            if (w_issue) begin
                infl_x_q    <= x_q;
                infl_y_q    <= y_q;
                infl_last_q <= w_last_rd;
            end
        end
    end

    // Entry 0 is the head and drives the stream outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val0_q <= 1'b0;
            val1_q <= 1'b0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            case ({infl_q, w_pop})
                2'b01: begin
                    ent0_q <= ent1_q;
                    val0_q <= val1_q;
                    val1_q <= 1'b0;
                end
                2'b10: begin
                    if (!val0_q) begin
                        ent0_q <= w_new;
                        val0_q <= 1'b1;
                    end else begin
                        ent1_q <= w_new;
                        val1_q <= 1'b1;
                    end
                end
                2'b11: begin
                    if (val1_q) begin
                        ent0_q <= ent1_q;
                        ent1_q <= w_new;
                    end else begin
                        ent0_q <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_addr0 = addr0_q;
    assign rd_addr1 = addr1_q;
    assign rd_addr2 = addr2_q;
    assign m_valid  = val0_q;
    assign m_top    = ent0_q[DATA_WIDTH-1:0];
    assign m_mid    = ent0_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign m_bot    = ent0_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign m_x      = ent0_q[c_X_LSB +: 16];
    assign m_y      = ent0_q[c_Y_LSB +: 16];
    assign m_last   = ent0_q[c_LAST_B];

endmodule

`default_nettype wire

// File: tb/tb_bram_window_reader.sv
`default_nettype none
// Bench for bram_window_reader on a 4x4 frame. The BRAM image holds mem[a]=a and is
// read through the registered address, so data for an address set on one edge is sampled on the next.
module tb_bram_window_reader;
    localparam int DW = 22;
    localparam int AW = 18;
    localparam int W  = 4;
    localparam int H  = 4;
`ifdef BORDER_REPLICATE_EN
    localparam int Y0 = 0;
    localparam int Y1 = H - 1;
`else
    localparam int Y0 = 1;
    localparam int Y1 = H - 2;
`endif
    localparam int NBEATS = W * (Y1 - Y0 + 1);

    typedef struct packed {
        logic [DW-1:0] top;
        logic [DW-1:0] mid;
        logic [DW-1:0] bot;
        logic [15:0]   x;
        logic [15:0]   y;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, m_valid, m_last;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2;
    logic [DW-1:0] dout0, dout1, dout2, m_top, m_mid, m_bot;
    logic [15:0]   m_x, m_y;

    bram_window_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .dout0(dout0), .dout1(dout1), .dout2(dout2),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_top(m_top), .m_mid(m_mid), .m_bot(m_bot),
        .m_x(m_x), .m_y(m_y), .m_last(m_last)
    );

    always #5 clk = ~clk;

    assign dout0 = DW'(rd_addr0);
    assign dout1 = DW'(rd_addr1);
    assign dout2 = DW'(rd_addr2);

    int      n_checks = 0;
    int      n_errors = 0;
    beat_t   sb[$];
    int      frame_beats = 0;
    int      done_cnt = 0;
    logic [AW-1:0] first_mid = '0;
    beat_t   first_seen, last_seen, prev_beat, cur;
    bit      prev_stall = 1'b0;

    assign cur = {m_top, m_mid, m_bot, m_x, m_y, m_last};

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int t, input int m, input int b, input int x, input int y, input bit l);
        beat_t r;
        r.top = DW'(t); r.mid = DW'(m); r.bot = DW'(b);
        r.x = 16'(x); r.y = 16'(y); r.last = l;
        return r;
    endfunction

    // Stream monitor: sampled mid-cycle, a beat counts as accepted when valid&ready here.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) check_eq("hold", {m_valid, cur}, {1'b1, prev_beat});
            if (busy && frame_beats >= 1)
                check_eq("ahead", int'(AW'(rd_addr1 - first_mid)) <= frame_beats + 1, 1);
            if (m_valid && m_ready) begin
                check_eq("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) check_eq("beat", cur, sb.pop_front());
                if (frame_beats == 0) first_seen = cur;
                if (m_last) last_seen = cur;
                frame_beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = cur;
            if (done) done_cnt++;
        end
    end

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_valid"}, m_valid, 0);
        check_eq({tag, "_last"}, m_last, 0);
        check_eq({tag, "_addr"}, {rd_addr0, rd_addr1, rd_addr2}, 0);
        check_eq({tag, "_data"}, {m_top, m_mid, m_bot, m_x, m_y}, 0);
    endtask

    task automatic begin_frame(input logic [AW-1:0] base);
        sb.delete();
        frame_beats = 0;
        done_cnt    = 0;
        prev_stall  = 1'b0;
        first_mid   = base + AW'(Y0 * W);
        for (int y = Y0; y <= Y1; y++) begin
            for (int x = 0; x < W; x++) begin
                beat_t b;
                logic [AW-1:0] mid, top, bot;
                mid = base + AW'(y * W + x);
                top = mid - AW'(W);
                bot = mid + AW'(W);
`ifdef BORDER_REPLICATE_EN
                if (y == 0) top = mid;
                if (y == H - 1) bot = mid;
`endif
                b.top = DW'(top); b.mid = DW'(mid); b.bot = DW'(bot);
                b.x = 16'(x); b.y = 16'(y); b.last = (x == W - 1) && (y == Y1);
                sb.push_back(b);
            end
        end
        @(posedge clk); #1;
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_on", busy, 1);
    endtask

    task automatic end_frame(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check_eq({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_beats"}, frame_beats, NBEATS);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_busy_off"}, busy, 0);
        check_eq({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #2;
        check_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Basic frame with first-beat latency
        begin_frame(AW'(0));
        @(negedge clk) check_eq("lat_c0", m_valid, 0);
        @(negedge clk) check_eq("lat_c1", m_valid, 0);
        @(negedge clk) check_eq("lat_c2", m_valid, 1);
        end_frame("basic");
`ifdef BORDER_REPLICATE_EN
        check_eq("basic_first", first_seen, mk(0, 0, 4, 0, 0, 0));
        check_eq("basic_last", last_seen, mk(11, 15, 15, 3, 3, 1));
`else
        check_eq("basic_first", first_seen, mk(0, 4, 8, 0, 1, 0));
        check_eq("basic_last", last_seen, mk(7, 11, 15, 3, 2, 1));
`endif

        // Backpressure: 5-cycle stall after beat 1, then random ready
        begin_frame(AW'(0));
        fork
            begin
                int n = 0;
                while (frame_beats < 1 && n < 100) begin
                    @(posedge clk);
                    n++;
                end
                #1 m_ready = 1'b0;
                repeat (5) @(posedge clk);
                n = 0;
                while (done_cnt == 0 && n < 400) begin
                    #1 m_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    n++;
                end
                #1 m_ready = 1'b1;
            end
            end_frame("bp");
        join

        // Base offset
        begin_frame(AW'(100));
        end_frame("base");
`ifdef BORDER_REPLICATE_EN
        check_eq("base_first", first_seen, mk(100, 100, 104, 0, 0, 0));
        check_eq("base_last", last_seen, mk(111, 115, 115, 3, 3, 1));
`else
        check_eq("base_first", first_seen, mk(100, 104, 108, 0, 1, 0));
        check_eq("base_last", last_seen, mk(107, 111, 115, 3, 2, 1));
`endif

        // start pulsed while busy must be ignored
        begin_frame(AW'(0));
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(200);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = '0;
        end_frame("restart");

        // Reset mid-frame, then a clean frame
        begin_frame(AW'(0));
        begin
            int n = 0;
            while (frame_beats < 3 && n < 100) begin
                @(posedge clk);
                n++;
            end
            check_eq("midrst_reached", frame_beats >= 3, 1);
        end
        #1 rst = 1'b1;
        #1;
        check_zero("midrst");
        repeat (3) @(posedge clk);
        check_eq("midrst_no_done", done_cnt, 0);
        @(negedge clk) rst = 1'b0;
        begin_frame(AW'(0));
        end_frame("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
